// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: definitions shared by the load/store stage, its load
// extender, the mm_* interface and the testbench.
//   - funct3 width/sign codes (RV32I loads/stores)
//   - FSM state encoding (exposed on mem_stage.dbg_state)
//   - mm_cu "bytes minus one" encodings and the funct3 -> mm_cu helper
package mem_stage_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] CU_BYTE = 2'd0;
  localparam logic [1:0] CU_HALF = 2'd1;
  localparam logic [1:0] CU_WORD = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  // Transfer size comes from funct3[1:0] only; 2'b11 has no RV32I meaning
  // and is sent as a full word.
  function automatic logic [1:0] f3_to_cu(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return CU_BYTE;
      2'b01:   return CU_HALF;
      default: return CU_WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: data port between the load/store stage and the memory
// controller.
//   master (stage)      : drives mm_e, mm_a, mm_n_i, mm_wr, mm_cu; reads mm_ok, mm_n_o
//   slave  (controller) : the mirror image
// Handshake: level-held request. The master raises mm_e with mm_a/mm_n_i/
// mm_wr/mm_cu stable and keeps all of them unchanged until it samples
// mm_ok = 1; in that cycle the transfer is complete (mm_n_o carries load
// data). The master then drops mm_e and must see mm_ok return to 0 before
// raising mm_e again, so each request is delimited by a falling edge.
interface mem_stage_if
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            mm_e;
  logic [XLEN-1:0] mm_a;
  logic [XLEN-1:0] mm_n_i;
  logic            mm_wr;
  logic [1:0]      mm_cu;
  logic            mm_ok;
  logic [XLEN-1:0] mm_n_o;

  modport master (
    output mm_e, mm_a, mm_n_i, mm_wr, mm_cu,
    input  mm_ok, mm_n_o
  );

  modport slave (
    input  mm_e, mm_a, mm_n_i, mm_wr, mm_cu,
    output mm_ok, mm_n_o
  );
endinterface

// File: rtl/mem_stage_ext.sv
// mem_ext: combinational load-data extender.
//   i_f3  : RV32I load funct3 (LB/LH/LW/LBU/LHU)
//   i_raw : raw little-endian load word from the controller
//   o_data: sign- or zero-extended writeback value
// Codes without a sub-word meaning pass the raw word through unchanged.
module mem_ext
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_f3,
  input  logic [XLEN-1:0] i_raw,
  output logic [XLEN-1:0] o_data
);

  always_comb begin
    o_data = i_raw;
    case (i_f3)
      F3_B:    o_data = {{(XLEN-8){i_raw[7]}},   i_raw[7:0]};
      F3_BU:   o_data = {{(XLEN-8){1'b0}},       i_raw[7:0]};
      F3_H:    o_data = {{(XLEN-16){i_raw[15]}}, i_raw[15:0]};
      F3_HU:   o_data = {{(XLEN-16){1'b0}},      i_raw[15:0]};
      default: o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: load/store pipeline stage in front of the memory controller.
// Non-memory results go straight to writeback; loads/stores run the
// level-held mm_* request handshake while stalling upstream.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   ex_*              instruction from the EX/MEM latch
//   stall_o           hold EX/MEM latch and everything upstream
//   mm                mem_stage_if.master towards the memory controller
//   wb_vld/rd/data    registered writeback
//   dbg_state         current FSM state
// Build option: define MEM_STAT_EN to add the free-running 32-bit counters
//   stat_ld, stat_st (completed loads/stores) and stat_stall (stall cycles).
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_vld,
  input  logic            ex_ld,
  input  logic            ex_st,
  input  logic [2:0]      ex_f3,
  input  logic [XLEN-1:0] ex_addr,
  input  logic [XLEN-1:0] ex_wdata,
  input  logic [XLEN-1:0] ex_res,
  input  logic [REGW-1:0] ex_rd,
  output logic            stall_o,
  mem_stage_if.master     mm,
  output logic            wb_vld,
  output logic [REGW-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output state_t          dbg_state
`ifdef MEM_STAT_EN
  ,
  output logic [31:0]     stat_ld,
  output logic [31:0]     stat_st,
  output logic [31:0]     stat_stall
`endif
);

  state_t          r_state;
  logic            r_mm_e;
  logic [XLEN-1:0] r_mm_a;
  logic [XLEN-1:0] r_mm_n_i;
  logic            r_mm_wr;
  logic [1:0]      r_mm_cu;
  logic [2:0]      r_f3;
  logic            r_wb_vld;
  logic [REGW-1:0] r_wb_rd;
  logic [XLEN-1:0] r_wb_data;

  logic            w_mem_op;
  logic            w_done;
  logic [XLEN-1:0] w_ext;

  assign w_mem_op = ex_vld & (ex_ld | ex_st);
  assign w_done   = (r_state == ST_REQ) & mm.mm_ok;

  // Upstream is released in the completion cycle itself; anything arriving
  // while we wait for mm_ok to fall is held.
  assign stall_o = (r_state == ST_RELEASE) | (w_mem_op & ~w_done);

  mem_ext #(.XLEN(XLEN)) u_ext (
    .i_f3  (r_f3),
    .i_raw (mm.mm_n_o),
    .o_data(w_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_mm_e    <= 1'b0;
      r_mm_a    <= '0;
      r_mm_n_i  <= '0;
      r_mm_wr   <= 1'b0;
      r_mm_cu   <= CU_BYTE;
      r_f3      <= F3_B;
      r_wb_vld  <= 1'b0;
      r_wb_rd   <= '0;
      r_wb_data <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_mem_op) begin
            r_mm_a   <= ex_addr;
            r_mm_n_i <= ex_wdata;
            r_mm_wr  <= ex_st;
            r_mm_cu  <= f3_to_cu(ex_f3);
            r_f3     <= ex_f3;
            r_mm_e   <= 1'b1;
            r_wb_vld <= 1'b0;
            r_state  <= ST_REQ;
          end else if (ex_vld) begin
            r_wb_vld  <= 1'b1;
            r_wb_rd   <= ex_rd;
            r_wb_data <= ex_res;
          end else begin
            r_wb_vld <= 1'b0;
          end
        end

        ST_REQ: begin
          r_wb_vld <= 1'b0;
          if (mm.mm_ok) begin
            r_mm_e  <= 1'b0;
            r_state <= ST_RELEASE;
            // ex_rd is still valid here: the latch was held until now.
            if (!r_mm_wr) begin
              r_wb_vld  <= 1'b1;
              r_wb_rd   <= ex_rd;
              r_wb_data <= w_ext;
            end
          end
        end

        ST_RELEASE: begin
          r_wb_vld <= 1'b0;
          if (!mm.mm_ok) r_state <= ST_IDLE;
        end

        default: begin
          r_state  <= ST_IDLE;
          r_mm_e   <= 1'b0;
          r_wb_vld <= 1'b0;
        end
      endcase
    end
  end

  assign mm.mm_e   = r_mm_e;
  assign mm.mm_a   = r_mm_a;
  assign mm.mm_n_i = r_mm_n_i;
  assign mm.mm_wr  = r_mm_wr;
  assign mm.mm_cu  = r_mm_cu;

  assign wb_vld    = r_wb_vld;
  assign wb_rd     = r_wb_rd;
  assign wb_data   = r_wb_data;
  assign dbg_state = r_state;

`ifdef MEM_STAT_EN
  logic [31:0] r_stat_ld;
  logic [31:0] r_stat_st;
  logic [31:0] r_stat_stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_ld    <= '0;
      r_stat_st    <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_done & ~r_mm_wr) r_stat_ld <= r_stat_ld + 32'd1;
      if (w_done &  r_mm_wr) r_stat_st <= r_stat_st + 32'd1;
      if (stall_o)           r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_ld    = r_stat_ld;
  assign stat_st    = r_stat_st;
  assign stat_stall = r_stat_stall;
`endif

endmodule
